// File: rtl/full_adder.sv
// One-bit full adder cell, the leaf of the ripple slices.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_slice.sv
// N-bit combinational ripple-carry adder built from full_adder cells.
module rca_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] w_c;

    assign w_c[0] = cin;
    assign cout   = w_c[N];

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (w_c[i]),
            .sum (sum[i]),
            .cout(w_c[i+1])
        );
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: a+b+cin over NDIG cycles, DIGIT bits per cycle,
// carry held in a register between digits. start/busy/done handshake.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_chk
        $fatal(1, "digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    logic             r_state;
    logic             w_state_nxt;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] w_opa_shr;
    logic [WIDTH-1:0] w_opb_shr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_msb_a;
    logic             r_msb_b;
    logic [DIGIT-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_res_nxt;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    // Combinational slice: low digit of each operand plus the stored carry.
    rca_slice #(.N(DIGIT)) u_slice (
        .a   (r_opa[DIGIT-1:0]),
        .b   (r_opb[DIGIT-1:0]),
        .cin (r_carry),
        .sum (w_slice_sum),
        .cout(w_slice_cout)
    );

    // The result register only needs the upper NDIG-1 digits: the final
    // digit goes straight from the slice into sum at completion.
    if (NDIG > 1) begin : g_multi
        logic [WIDTH-DIGIT-1:0] r_res;

        assign w_res_nxt = {w_slice_sum, r_res};
        assign w_opa_shr = {{DIGIT{1'b0}}, r_opa[WIDTH-1:DIGIT]};
        assign w_opb_shr = {{DIGIT{1'b0}}, r_opb[WIDTH-1:DIGIT]};

        // Partial-result shift register, new digit enters at the top.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_res <= '0;
            else if (r_state == S_RUN)
                r_res <= w_res_nxt[WIDTH-1:DIGIT];
        end
    end else begin : g_single
        assign w_res_nxt = w_slice_sum;
        assign w_opa_shr = '0;
        assign w_opb_shr = '0;
    end

    // Next-state logic: accept only in IDLE, finish on the last digit.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(NDIG - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Operand capture and per-digit shifting, carry and counter update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_msb_a <= 1'b0;
            r_msb_b <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= a;
            r_opb   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            // Operand MSBs shift out early; keep them for the overflow test.
            r_msb_a <= a[WIDTH-1];
            r_msb_b <= b[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_opa   <= w_opa_shr;
            r_opb   <= w_opb_shr;
            r_carry <= w_slice_cout;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Visible results change only at completion; done pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_sum  <= w_res_nxt;
                r_cout <= w_slice_cout;
                r_ovf  <= (r_msb_a == r_msb_b) && (w_res_nxt[WIDTH-1] != r_msb_a);
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench: main 16/4 instance with directed vectors, plus a sweep
// of (4,1) (4,4) (8,2) (16,16) instances against a+b+cin.
module tb_digit_serial_adder;

    localparam int MW   = 16;
    localparam int MD   = 4;
    localparam int MND  = MW / MD;
    localparam int NSW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- main instance ----------------
    logic          m_start, m_cin, m_busy, m_done, m_cout, m_ovf;
    logic [MW-1:0] m_a, m_b, m_sum;

    digit_serial_adder #(.WIDTH(MW), .DIGIT(MD)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(m_start),
        .a    (m_a),
        .b    (m_b),
        .cin  (m_cin),
        .busy (m_busy),
        .done (m_done),
        .sum  (m_sum),
        .cout (m_cout),
        .ovf  (m_ovf)
    );

    typedef struct {
        logic [MW-1:0] s;
        logic          c;
        logic          o;
        int            acc;
    } exp_t;

    exp_t          mq[$];
    exp_t          me;
    logic [MW-1:0] last_s;
    logic          last_c, last_o;

    // Monitor: pop on done, otherwise outputs must hold the last result.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            last_s = '0;
            last_c = 1'b0;
            last_o = 1'b0;
        end else if (m_done) begin
            if (mq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_spurious_done: got done=1 required no pending op (sum=%0h)", m_sum);
            end else begin
                me = mq.pop_front();
                chk("main_sum",     32'(m_sum),  32'(me.s));
                chk("main_cout",    32'(m_cout), 32'(me.c));
                chk("main_ovf",     32'(m_ovf),  32'(me.o));
                chk("main_latency", 32'(cyc - me.acc), 32'(MND + 1));
                last_s = me.s;
                last_c = me.c;
                last_o = me.o;
            end
        end else begin
            chk("main_hold_sum",  32'(m_sum),  32'(last_s));
            chk("main_hold_cout", 32'(m_cout), 32'(last_c));
            chk("main_hold_ovf",  32'(m_ovf),  32'(last_o));
        end
    end

    // Issue one op at the first idle negedge; start stays high for `hold`
    // negedges while the operands are scrambled.
    task automatic issue(input logic [MW-1:0] ta, input logic [MW-1:0] tb_, input logic tc,
                         input int hold, input logic [MW-1:0] es, input logic ec, input logic eo);
        int   n;
        exp_t x;
        n = 0;
        while (m_busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL main_idle_wait: got busy=%b required 0 within 50 cycles", m_busy);
        end
        m_a     = ta;
        m_b     = tb_;
        m_cin   = tc;
        m_start = 1'b1;
        x.s = es;
        x.c = ec;
        x.o = eo;
        x.acc = cyc;
        mq.push_back(x);
        repeat (hold) begin
            @(negedge clk);
            m_a   = MW'($urandom);
            m_b   = MW'($urandom);
            m_cin = 1'($urandom);
        end
        m_start = 1'b0;
    endtask

    // ---------------- sweep instances ----------------
    logic           sw_start, sw_cin;
    logic [15:0]    sw_a, sw_b;
    logic [NSW-1:0] sw_busy_v;

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        localparam int W  = (g == 0) ? 4 : (g == 1) ? 4 : (g == 2) ? 8 : 16;
        localparam int D  = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 2 : 16;
        localparam int ND = W / D;

        logic         sbusy, sdone, scout, sovf;
        logic [W-1:0] ssum;
        logic [W+1:0] q[$];
        logic [W+1:0] e;
        logic [W:0]   t;
        int           bcnt;

        digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_sw (
            .clk  (clk),
            .rst_n(rst_n),
            .start(sw_start),
            .a    (sw_a[W-1:0]),
            .b    (sw_b[W-1:0]),
            .cin  (sw_cin),
            .busy (sbusy),
            .done (sdone),
            .sum  (ssum),
            .cout (scout),
            .ovf  (sovf)
        );

        assign sw_busy_v[g] = sbusy;

        // Reference model pushed when the DUT accepts.
        always @(posedge clk) begin
            if (rst_n && sw_start && !sbusy) begin
                t = {1'b0, sw_a[W-1:0]} + {1'b0, sw_b[W-1:0]} + {{W{1'b0}}, sw_cin};
                q.push_back({(sw_a[W-1] == sw_b[W-1]) && (t[W-1] != sw_a[W-1]), t});
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                bcnt = 0;
            end else begin
                if (sbusy) bcnt++;
                if (sdone) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sw%0d_spurious_done: got done=1 required no pending op", g);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("sw%0d_sum", g),   32'(ssum),  32'(e[W-1:0]));
                        chk($sformatf("sw%0d_cout", g),  32'(scout), 32'(e[W]));
                        chk($sformatf("sw%0d_ovf", g),   32'(sovf),  32'(e[W+1]));
                        chk($sformatf("sw%0d_busyw", g), 32'(bcnt),  32'(ND));
                    end
                    bcnt = 0;
                end
            end
        end
    end

    task automatic sw_issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
        int n;
        sw_a     = ta;
        sw_b     = tb_;
        sw_cin   = tc;
        sw_start = 1'b1;
        @(negedge clk);
        sw_start = 1'b0;
        n = 0;
        while ((|sw_busy_v) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL sw_idle_wait: got busy=%b required 0 within 20 cycles", sw_busy_v);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ra, rb;
        int          n;
        rst_n    = 1'b0;
        m_start  = 1'b0;
        m_a      = '0;
        m_b      = '0;
        m_cin    = 1'b0;
        sw_start = 1'b0;
        sw_a     = '0;
        sw_b     = '0;
        sw_cin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_done", 32'(m_done), 32'd0);
        chk("rst_sum",  32'(m_sum),  32'd0);
        chk("rst_cout", 32'(m_cout), 32'd0);
        chk("rst_ovf",  32'(m_ovf),  32'd0);
        rst_n = 1'b1;

        // Directed vectors, each accepted in the done cycle of the previous.
        issue(16'h1234, 16'h0F0F, 1'b0, 1, 16'h2143, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0000, 1'b1, 1, 16'h0000, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1);
        issue(16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1, 1'b1);
        issue(16'hABCD, 16'h1111, 1'b1, 1, 16'hBCDF, 1'b0, 1'b0);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1, 16'hFFFF, 1'b1, 1'b0);
        // start held through the whole run with garbage operands: no restart.
        issue(16'h0102, 16'h0304, 1'b0, MND + 1, 16'h0406, 1'b0, 1'b0);

        // Asynchronous reset in the second RUN cycle discards the op.
        issue(16'h1111, 16'h2222, 1'b0, 1, 16'h3333, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(m_busy), 32'd0);
        chk("midrst_done", 32'(m_done), 32'd0);
        chk("midrst_sum",  32'(m_sum),  32'd0);
        chk("midrst_cout", 32'(m_cout), 32'd0);
        chk("midrst_ovf",  32'(m_ovf),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0001, 16'h0001, 1'b0, 1, 16'h0002, 1'b0, 1'b0);
        issue(16'hFFF0, 16'h0010, 1'b0, 1, 16'h0000, 1'b1, 1'b0);

        n = 0;
        while (mq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL main_drain: got %0d pending results required 0", mq.size());
        end
        repeat (3) @(negedge clk);

        // Sweep: low nibble exhaustive (covers the 4-bit instances fully).
        for (int i = 0; i < 512; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ra[3:0] = i[3:0];
            rb[3:0] = i[7:4];
            sw_issue(ra, rb, i[8]);
        end
        for (int i = 0; i < 1000; i++) begin
            sw_issue(16'($urandom), 16'($urandom), 1'($urandom));
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
